// File: rtl/munoc_activity_history_monitor_pkg.sv
// rtl/munoc_activity_history_monitor_pkg.sv - shared width helpers for the activity history monitor
// Purpose: index-width helper used by the monitor top and its per-channel slice.
// Ports: none (package).
package munoc_activity_history_monitor_pkg;

  // Index width for a table of n entries; never narrower than one bit so that
  // single-entry configurations still get a legal select signal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/munoc_activity_channel.sv
// rtl/munoc_activity_channel.sv - one monitored channel: activity counter, history, peak, alarm
// Purpose: counts active cycles in the current window, and on window close stores the
//   quantised sample into its circular history and updates latest/peak/alarm.
// Ports: clk, rst (sync, active-high), enable, clear, close (window-close strobe from top),
//   active, alarm_clr, wr_ptr (history slot to write), rd_slot (history slot to read),
//   threshold; outputs rd_data, latest_sample, peak, alarm.
module munoc_activity_channel
  import munoc_activity_history_monitor_pkg::*;
#(
  parameter int unsigned BW_WINDOW     = 10,
  parameter int unsigned BW_SAMPLE     = 4,
  parameter int unsigned HISTORY_DEPTH = 8,
  parameter int unsigned IDX_W         = idx_width(HISTORY_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 close,
  input  logic                 active,
  input  logic                 alarm_clr,
  input  logic [IDX_W-1:0]     wr_ptr,
  input  logic [IDX_W-1:0]     rd_slot,
  input  logic [BW_SAMPLE-1:0] threshold,
  output logic [BW_SAMPLE-1:0] rd_data,
  output logic [BW_SAMPLE-1:0] latest_sample,
  output logic [BW_SAMPLE-1:0] peak,
  output logic                 alarm
);

  logic [BW_WINDOW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BW_SAMPLE-1:0] hist_q [HISTORY_DEPTH];
  logic [BW_SAMPLE-1:0] hist_d [HISTORY_DEPTH];
  logic [BW_SAMPLE-1:0] latest_q, latest_d, peak_q, peak_d, sample;
  logic                 alarm_q, alarm_d;

  always_comb begin
    // The closing cycle's own activity is part of the sample, hence sample from cnt_inc.
    cnt_inc  = (active && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    sample   = cnt_inc[BW_WINDOW-1 -: BW_SAMPLE];
    cnt_d    = cnt_q;
    hist_d   = hist_q;
    latest_d = latest_q;
    peak_d   = peak_q;
    alarm_d  = alarm_q;
    if (clear) begin
      cnt_d    = '0;
      for (int i = 0; i < HISTORY_DEPTH; i++) hist_d[i] = '1;
      latest_d = '1;
      peak_d   = '0;
      alarm_d  = 1'b0;
    end else if (enable) begin
      if (close) begin
        cnt_d          = '0;
        hist_d[wr_ptr] = sample;
        latest_d       = sample;
        if (sample > peak_q) peak_d = sample;
        // A new alarm-level sample beats a simultaneous clear request.
        if (sample >= threshold) alarm_d = 1'b1;
        else if (alarm_clr)      alarm_d = 1'b0;
      end else begin
        cnt_d = cnt_inc;
        if (alarm_clr) alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      for (int i = 0; i < HISTORY_DEPTH; i++) hist_q[i] <= '1;
      latest_q <= '1;
      peak_q   <= '0;
      alarm_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      latest_q <= latest_d;
      peak_q   <= peak_d;
      alarm_q  <= alarm_d;
    end
  end

  assign rd_data       = hist_q[rd_slot];
  assign latest_sample = latest_q;
  assign peak          = peak_q;
  assign alarm         = alarm_q;

endmodule

// File: rtl/munoc_activity_history_monitor.sv
// rtl/munoc_activity_history_monitor.sv - multi-channel NoC link activity history monitor
// Purpose: shared window counter, history write pointer, fill level and read mux around
//   NUM_CH per-channel activity slices.
// Ports: clk, rst (sync, active-high), enable, clear, cfg_window_len, cfg_threshold, active,
//   alarm_clr, rd_ch, rd_idx (0 = newest); outputs rd_data, latest_sample, peak, alarm,
//   num_valid, window_done. Packed per-channel buses carry ch0 in the LSBs.
module munoc_activity_history_monitor
  import munoc_activity_history_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned BW_WINDOW     = 10,
  parameter int unsigned BW_SAMPLE     = 4,
  parameter int unsigned HISTORY_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 clear,
  input  logic [BW_WINDOW-1:0]                 cfg_window_len,
  input  logic [BW_SAMPLE-1:0]                 cfg_threshold,
  input  logic [NUM_CH-1:0]                    active,
  input  logic [NUM_CH-1:0]                    alarm_clr,
  input  logic [idx_width(NUM_CH)-1:0]         rd_ch,
  input  logic [idx_width(HISTORY_DEPTH)-1:0]  rd_idx,
  output logic [BW_SAMPLE-1:0]                 rd_data,
  output logic [NUM_CH*BW_SAMPLE-1:0]          latest_sample,
  output logic [NUM_CH*BW_SAMPLE-1:0]          peak,
  output logic [NUM_CH-1:0]                    alarm,
  output logic [$clog2(HISTORY_DEPTH+1)-1:0]   num_valid,
  output logic                                 window_done
);

  localparam int unsigned CH_W  = idx_width(NUM_CH);
  localparam int unsigned IDX_W = idx_width(HISTORY_DEPTH);
  localparam int unsigned NV_W  = $clog2(HISTORY_DEPTH + 1);
  localparam int unsigned SW    = IDX_W + 2;

  logic [BW_WINDOW-1:0] win_cnt_q, win_cnt_d, win_len_q, win_len_d, cur_len;
  logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d, rd_slot;
  logic [NV_W-1:0]      num_valid_q, num_valid_d;
  logic                 window_done_q, window_done_d, close;
  logic [SW-1:0]        slot_sum;

  always_comb begin
    // At a window start the live cfg value is used, so the very first window after
    // reset/clear already honours cfg_window_len; later cycles use the latched copy.
    cur_len       = (win_cnt_q == '0) ? cfg_window_len : win_len_q;
    close         = enable && (win_cnt_q == cur_len);
    win_cnt_d     = win_cnt_q;
    win_len_d     = win_len_q;
    wr_ptr_d      = wr_ptr_q;
    num_valid_d   = num_valid_q;
    // Pulse, not state: it drops after one cycle even if enable goes low.
    window_done_d = close && !clear;
    if (clear) begin
      win_cnt_d   = '0;
      wr_ptr_d    = '0;
      num_valid_d = '0;
    end else if (enable) begin
      if (win_cnt_q == '0) win_len_d = cfg_window_len;
      if (close) begin
        win_cnt_d = '0;
        wr_ptr_d  = (wr_ptr_q == IDX_W'(HISTORY_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (num_valid_q != NV_W'(HISTORY_DEPTH)) num_valid_d = num_valid_q + 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q     <= '0;
      win_len_q     <= '0;
      wr_ptr_q      <= '0;
      num_valid_q   <= '0;
      window_done_q <= 1'b0;
    end else begin
      win_cnt_q     <= win_cnt_d;
      win_len_q     <= win_len_d;
      wr_ptr_q      <= wr_ptr_d;
      num_valid_q   <= num_valid_d;
      window_done_q <= window_done_d;
    end
  end

  // Newest sample sits one behind wr_ptr; the 2*DEPTH bias keeps the subtraction
  // non-negative for any rd_idx, including non-power-of-two depths.
  assign slot_sum = SW'(wr_ptr_q) + SW'(2 * HISTORY_DEPTH - 1) - SW'(rd_idx);
  assign rd_slot  = IDX_W'(slot_sum % SW'(HISTORY_DEPTH));

  // Mux is padded to the full rd_ch range; unused channel codes read as 0.
  logic [BW_SAMPLE-1:0] rd_mux [2**CH_W];

  for (genvar c = 0; c < 2**CH_W; c++) begin : g_ch
    if (c < NUM_CH) begin : g_used
      munoc_activity_channel #(
        .BW_WINDOW    (BW_WINDOW),
        .BW_SAMPLE    (BW_SAMPLE),
        .HISTORY_DEPTH(HISTORY_DEPTH)
      ) u_channel (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .close        (close),
        .active       (active[c]),
        .alarm_clr    (alarm_clr[c]),
        .wr_ptr       (wr_ptr_q),
        .rd_slot      (rd_slot),
        .threshold    (cfg_threshold),
        .rd_data      (rd_mux[c]),
        .latest_sample(latest_sample[c*BW_SAMPLE +: BW_SAMPLE]),
        .peak         (peak[c*BW_SAMPLE +: BW_SAMPLE]),
        .alarm        (alarm[c])
      );
    end else begin : g_unused
      assign rd_mux[c] = '0;
    end
  end

  assign rd_data     = rd_mux[rd_ch];
  assign num_valid   = num_valid_q;
  assign window_done = window_done_q;

endmodule

// File: tb/tb_munoc_activity_history_monitor.sv
// tb/tb_munoc_activity_history_monitor.sv - directed self-checking bench for the activity monitor
module tb_munoc_activity_history_monitor;

  logic       clk = 1'b0;
  logic       rst, enable, clear;
  logic [3:0] cfg_window_len;
  logic [1:0] cfg_threshold, active, alarm_clr;
  logic       rd_ch;
  logic [1:0] rd_idx;
  logic [1:0] rd_data;
  logic [3:0] latest_sample, peak;
  logic [1:0] alarm;
  logic [2:0] num_valid;
  logic       window_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  munoc_activity_history_monitor #(
    .NUM_CH(2), .BW_WINDOW(4), .BW_SAMPLE(2), .HISTORY_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .cfg_window_len(cfg_window_len), .cfg_threshold(cfg_threshold),
    .active(active), .alarm_clr(alarm_clr), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .rd_data(rd_data), .latest_sample(latest_sample), .peak(peak), .alarm(alarm),
    .num_valid(num_valid), .window_done(window_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0; active = 2'b00; alarm_clr = 2'b00;
    cfg_window_len = 4'd15; cfg_threshold = 2'd3; rd_ch = 1'b0; rd_idx = 2'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One 16-cycle window with ch0 active for the first cnt cycles; alarm_clr[0] at clr_at.
  task automatic run_window(input int cnt, input int clr_at);
    for (int i = 0; i < 16; i++) begin
      active    = {1'b0, (i < cnt)};
      alarm_clr = {1'b0, (i == clr_at)};
      tick();
    end
    active = 2'b00; alarm_clr = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (latest_sample !== 4'hF) begin n_err++; $display("FAIL rst_latest got %h exp F", latest_sample); end
    n_cmp++; if (peak !== 4'h0) begin n_err++; $display("FAIL rst_peak got %h exp 0", peak); end
    n_cmp++; if (alarm !== 2'b00) begin n_err++; $display("FAIL rst_alarm got %b exp 00", alarm); end
    n_cmp++; if (num_valid !== 3'd0) begin n_err++; $display("FAIL rst_num_valid got %0d exp 0", num_valid); end
    n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL rst_window_done got %b exp 0", window_done); end
    rd_ch = 1'b1; rd_idx = 2'd3; #1;
    n_cmp++; if (rd_data !== 2'd3) begin n_err++; $display("FAIL rst_rd_data got %0d exp 3", rd_data); end
  endtask

  task automatic test_saturate_window();
    do_reset();
    enable = 1'b1; active = 2'b01;
    repeat (15) tick();
    n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL sat_early_done got %b exp 0", window_done); end
    n_cmp++; if (latest_sample !== 4'hF) begin n_err++; $display("FAIL sat_early_latest got %h exp F", latest_sample); end
    tick();
    n_cmp++; if (latest_sample !== 4'h3) begin n_err++; $display("FAIL sat_latest got %h exp 3", latest_sample); end
    n_cmp++; if (window_done !== 1'b1) begin n_err++; $display("FAIL sat_done got %b exp 1", window_done); end
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL sat_num_valid got %0d exp 1", num_valid); end
    tick();
    n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL sat_done_pulse got %b exp 0", window_done); end
    repeat (14) tick();
    n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL sat_done2_early got %b exp 0", window_done); end
    tick();
    n_cmp++; if (window_done !== 1'b1) begin n_err++; $display("FAIL sat_done2 got %b exp 1", window_done); end
    n_cmp++; if (num_valid !== 3'd2) begin n_err++; $display("FAIL sat_num_valid2 got %0d exp 2", num_valid); end
    n_cmp++; if (alarm !== 2'b01) begin n_err++; $display("FAIL sat_alarm got %b exp 01", alarm); end
    active = 2'b00;
  endtask

  task automatic test_partial_activity();
    logic [7:0] pat;
    do_reset();
    cfg_window_len = 4'd7; rd_ch = 1'b0; rd_idx = 2'd0; #1;
    n_cmp++; if (rd_data !== 2'd3) begin n_err++; $display("FAIL part_empty_rd got %0d exp 3", rd_data); end
    n_cmp++; if (num_valid !== 3'd0) begin n_err++; $display("FAIL part_empty_nv got %0d exp 0", num_valid); end
    enable = 1'b1;
    pat = 8'b1011_0111;
    for (int i = 0; i < 8; i++) begin
      active = {1'b0, pat[i]};
      tick();
    end
    active = 2'b00;
    n_cmp++; if (latest_sample !== 4'h1) begin n_err++; $display("FAIL part_latest got %h exp 1", latest_sample); end
    n_cmp++; if (rd_data !== 2'd1) begin n_err++; $display("FAIL part_rd_ch0 got %0d exp 1", rd_data); end
    rd_ch = 1'b1; #1;
    n_cmp++; if (rd_data !== 2'd0) begin n_err++; $display("FAIL part_rd_ch1 got %0d exp 0", rd_data); end
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL part_nv got %0d exp 1", num_valid); end
  endtask

  task automatic test_history_wrap();
    int counts [5];
    logic [1:0] exp_rd [4];
    counts = '{0, 4, 8, 12, 4};
    exp_rd = '{2'd1, 2'd3, 2'd2, 2'd1};
    do_reset();
    enable = 1'b1;
    for (int w = 0; w < 5; w++) run_window(counts[w], -1);
    n_cmp++; if (num_valid !== 3'd4) begin n_err++; $display("FAIL wrap_nv got %0d exp 4", num_valid); end
    n_cmp++; if (peak !== 4'h3) begin n_err++; $display("FAIL wrap_peak got %h exp 3", peak); end
    n_cmp++; if (latest_sample !== 4'h1) begin n_err++; $display("FAIL wrap_latest got %h exp 1", latest_sample); end
    enable = 1'b0; rd_ch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      n_cmp++; if (rd_data !== exp_rd[i]) begin n_err++; $display("FAIL wrap_rd_idx%0d got %0d exp %0d", i, rd_data, exp_rd[i]); end
    end
  endtask

  task automatic test_alarm();
    do_reset();
    cfg_threshold = 2'd2; enable = 1'b1;
    run_window(8, -1);
    n_cmp++; if (alarm !== 2'b01) begin n_err++; $display("FAIL alarm_set got %b exp 01", alarm); end
    run_window(0, 0);
    n_cmp++; if (alarm !== 2'b00) begin n_err++; $display("FAIL alarm_clr got %b exp 00", alarm); end
    run_window(12, 15);
    n_cmp++; if (alarm !== 2'b01) begin n_err++; $display("FAIL alarm_set_wins got %b exp 01", alarm); end
  endtask

  task automatic test_clear_enable();
    do_reset();
    enable = 1'b1;
    run_window(16, -1);
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL clr_pre_nv got %0d exp 1", num_valid); end
    active = 2'b01;
    repeat (15) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    rd_ch = 1'b0; rd_idx = 2'd0; #1;
    n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL clr_done got %b exp 0", window_done); end
    n_cmp++; if (num_valid !== 3'd0) begin n_err++; $display("FAIL clr_nv got %0d exp 0", num_valid); end
    n_cmp++; if (latest_sample !== 4'hF) begin n_err++; $display("FAIL clr_latest got %h exp F", latest_sample); end
    n_cmp++; if (rd_data !== 2'd3) begin n_err++; $display("FAIL clr_hist got %0d exp 3", rd_data); end
    n_cmp++; if (peak !== 4'h0) begin n_err++; $display("FAIL clr_peak got %h exp 0", peak); end
    repeat (15) tick();
    n_cmp++; if (num_valid !== 3'd0) begin n_err++; $display("FAIL clr_full_len_early got %0d exp 0", num_valid); end
    tick();
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL clr_full_len got %0d exp 1", num_valid); end
    repeat (8) tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    repeat (7) tick();
    n_cmp++; if (num_valid !== 3'd1 || window_done !== 1'b0) begin n_err++; $display("FAIL en_hold_early nv %0d done %b exp 1 0", num_valid, window_done); end
    tick();
    n_cmp++; if (num_valid !== 3'd2 || window_done !== 1'b1) begin n_err++; $display("FAIL en_hold_close nv %0d done %b exp 2 1", num_valid, window_done); end
    n_cmp++; if (latest_sample !== 4'h3) begin n_err++; $display("FAIL en_hold_latest got %h exp 3", latest_sample); end
    active = 2'b00;
  endtask

  task automatic test_reset_cfg();
    do_reset();
    enable = 1'b1; active = 2'b01;
    run_window(16, -1);
    active = 2'b01;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (latest_sample !== 4'hF || peak !== 4'h0) begin n_err++; $display("FAIL rstmid_lat_peak got %h %h exp F 0", latest_sample, peak); end
    n_cmp++; if (num_valid !== 3'd0 || alarm !== 2'b00 || window_done !== 1'b0) begin n_err++; $display("FAIL rstmid_state nv %0d alarm %b done %b exp 0 00 0", num_valid, alarm, window_done); end
    cfg_window_len = 4'd15;
    tick();
    cfg_window_len = 4'd3;
    repeat (14) tick();
    n_cmp++; if (num_valid !== 3'd0) begin n_err++; $display("FAIL cfgmid_early got %0d exp 0", num_valid); end
    tick();
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL cfgmid_close got %0d exp 1", num_valid); end
    repeat (3) tick();
    n_cmp++; if (num_valid !== 3'd1) begin n_err++; $display("FAIL cfgnew_early got %0d exp 1", num_valid); end
    tick();
    n_cmp++; if (num_valid !== 3'd2) begin n_err++; $display("FAIL cfgnew_close got %0d exp 2", num_valid); end
    n_cmp++; if (latest_sample !== 4'h1) begin n_err++; $display("FAIL cfgnew_latest got %h exp 1", latest_sample); end
    active = 2'b00;
  endtask

  initial begin
    test_reset();
    test_saturate_window();
    test_partial_activity();
    test_history_wrap();
    test_alarm();
    test_clear_enable();
    test_reset_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
